// File: rtl/dec_timer.sv
// Loadable, enable-gated down-counter with a registered one-cycle terminal-count
// pulse and optional auto-reload for periodic ticks.
module dec_timer #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLRN,
    input  logic             Ld,
    input  logic [WIDTH-1:0] LdVal,
    input  logic             En,
    input  logic             AutoRld,
    output logic [WIDTH-1:0] Q,
    output logic             Tc,
    output logic             Busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [WIDTH-1:0] rld_r, rld_nxt;
    logic             tc_r, tc_nxt;

    always_ff @(posedge CLK or negedge CLRN) begin
        if (!CLRN) begin
            state <= IDLE;
            q_r   <= '0;
            rld_r <= '0;
            tc_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            q_r   <= q_nxt;
            rld_r <= rld_nxt;
            tc_r  <= tc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q_r;
        rld_nxt   = rld_r;
        tc_nxt    = 1'b0;
        if (Ld) begin
            rld_nxt   = LdVal;
            q_nxt     = LdVal;
            state_nxt = (LdVal != ZERO) ? RUN : IDLE;
        end else if (state == RUN && En) begin
            if (q_r > ONE) begin
                q_nxt = q_r - ONE;
            end else if (q_r == ONE) begin
                // Terminal cycle: AutoRld is only looked at here.
                tc_nxt = 1'b1;
                if (AutoRld) begin
                    q_nxt = rld_r;
                end else begin
                    q_nxt     = ZERO;
                    state_nxt = IDLE;
                end
            end else begin
                // RUN with a zero count cannot be reached; fall back to IDLE
                // rather than decrementing past zero.
                state_nxt = IDLE;
            end
        end
    end

    assign Q    = q_r;
    assign Tc   = tc_r;
    assign Busy = (state == RUN);

endmodule

// File: tb/tb_dec_timer.sv
// Directed bench for dec_timer: one task per scenario, 8-bit and 4-bit instances.
module tb_dec_timer;

    logic       clk;
    logic       clrn;
    logic       ld, en, autorld;
    logic [7:0] ldval;
    logic [7:0] q;
    logic       tc, busy;
    logic       ld4, en4, autorld4;
    logic [3:0] ldval4;
    logic [3:0] q4;
    logic       tc4, busy4;

    int checks = 0;
    int errors = 0;

    dec_timer #(.WIDTH(8)) dut (
        .CLK(clk), .CLRN(clrn), .Ld(ld), .LdVal(ldval), .En(en),
        .AutoRld(autorld), .Q(q), .Tc(tc), .Busy(busy)
    );

    dec_timer #(.WIDTH(4)) dut4 (
        .CLK(clk), .CLRN(clrn), .Ld(ld4), .LdVal(ldval4), .En(en4),
        .AutoRld(autorld4), .Q(q4), .Tc(tc4), .Busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] qe, input logic tce, input logic be);
        checks++;
        if (q !== qe) begin
            errors++;
            $display("FAIL %s Q: got %0d expected %0d", name, q, qe);
        end
        checks++;
        if (tc !== tce) begin
            errors++;
            $display("FAIL %s Tc: got %0b expected %0b", name, tc, tce);
        end
        checks++;
        if (busy !== be) begin
            errors++;
            $display("FAIL %s Busy: got %0b expected %0b", name, busy, be);
        end
    endtask

    task automatic load(input logic [7:0] v, input logic ar);
        ld = 1'b1; ldval = v; autorld = ar; en = 1'b1;
        tick();
        ld = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        chk("reset_initial", 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        clrn = 1'b1;
        load(8'd5, 1'b0);
        chk("reset_load5", 8'd5, 1'b0, 1'b1);
        tick();
        tick();
        chk("reset_q3", 8'd3, 1'b0, 1'b1);
        #2 clrn = 1'b0;
        #1;
        chk("reset_async", 8'd0, 1'b0, 1'b0);
        #1 clrn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("reset_after_release", 8'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_oneshot();
        load(8'd4, 1'b0);
        chk("oneshot_load", 8'd4, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("oneshot_count", 8'(4 - k), (k == 4), (k < 4));
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("oneshot_hold", 8'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_autoreload();
        load(8'd3, 1'b1);
        chk("auto_load", 8'd3, 1'b0, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk("auto_period", 8'(3 - (k % 3)), ((k % 3) == 0), 1'b1);
        end
    endtask

    task automatic test_enable();
        logic       enp [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] eq  [5] = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd0};
        logic       etc [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       eb  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        load(8'd3, 1'b0);
        chk("enable_load", 8'd3, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            en = enp[k];
            tick();
            chk("enable_gate", eq[k], etc[k], eb[k]);
        end
        en = 1'b1;
    endtask

    task automatic test_collision();
        load(8'd2, 1'b1);
        tick();
        chk("collide_q1", 8'd1, 1'b0, 1'b1);
        load(8'd7, 1'b1);
        chk("collide_ld7", 8'd7, 1'b0, 1'b1);
        load(8'd0, 1'b1);
        chk("zero_load", 8'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("zero_hold", 8'd0, 1'b0, 1'b0);
        end
    endtask

    task automatic test_ld1_auto();
        load(8'd1, 1'b1);
        chk("ld1_load", 8'd1, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ld1_every_cycle", 8'd1, 1'b1, 1'b1);
        end
    endtask

    task automatic test_autorld_change();
        load(8'd3, 1'b1);
        tick();
        autorld = 1'b0;
        tick();
        chk("rldchg_q1", 8'd1, 1'b0, 1'b1);
        tick();
        chk("rldchg_terminal", 8'd0, 1'b1, 1'b0);
    endtask

    task automatic test_width4();
        ld4 = 1'b1; ldval4 = 4'd15; autorld4 = 1'b1; en4 = 1'b1;
        tick();
        ld4 = 1'b0;
        checks++;
        if (q4 !== 4'd15) begin
            errors++;
            $display("FAIL w4_load Q: got %0d expected 15", q4);
        end
        for (int k = 1; k <= 45; k++) begin
            tick();
            checks++;
            if (q4 !== 4'(15 - (k % 15))) begin
                errors++;
                $display("FAIL w4_count k=%0d Q: got %0d expected %0d", k, q4, 15 - (k % 15));
            end
            checks++;
            if (tc4 !== ((k % 15) == 0)) begin
                errors++;
                $display("FAIL w4_tc k=%0d Tc: got %0b expected %0b", k, tc4, ((k % 15) == 0));
            end
            checks++;
            if (busy4 !== 1'b1) begin
                errors++;
                $display("FAIL w4_busy k=%0d Busy: got %0b expected 1", k, busy4);
            end
        end
        en4 = 1'b0;
    endtask

    initial begin
        clrn = 1'b0;
        ld = 1'b0; en = 1'b0; autorld = 1'b0; ldval = '0;
        ld4 = 1'b0; en4 = 1'b0; autorld4 = 1'b0; ldval4 = '0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_enable();
        test_collision();
        test_ld1_auto();
        test_autorld_change();
        test_width4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
